// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//   Serial receiver for frames made of 1 start bit (0), MAXTAM data bits sent
//   LSB first, and 1 stop bit (1). The line is oversampled with 16 i_bd ticks
//   per bit. Each bit is sampled at its centre.
//   The baud tick generator is shared with the transmitter.
//
// Ports
//   i_clk        system clock, all state on the rising edge
//   i_reset      asynchronous reset, active low
//   i_bd         baud tick, 1-cycle pulse, 16 per bit period
//   i_Rx_Serial  asynchronous serial line, idle high
//   o_Rx_Byte    last correctly framed byte, held until the next good frame
//   o_Rx_Done    1-cycle pulse: o_Rx_Byte was updated
//   o_Rx_Err     1-cycle pulse: stop bit sampled low (framing error)
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int MAXTAM      = 8,
    parameter int BIT_COUNTER = 3
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_bd,
    input  logic              i_Rx_Serial,
    output logic [MAXTAM-1:0] o_Rx_Byte,
    output logic              o_Rx_Done,
    output logic              o_Rx_Err
);

    localparam int TICKS_MUESTREO = 16;

    // Tick values at which a decision is taken: the middle of the start bit,
    // and the middle of every later bit (a full bit period after the
    // previous decision point).
    localparam logic [3:0] MID_START = 4'(TICKS_MUESTREO / 2 - 1);
    localparam logic [3:0] LAST_TICK = 4'(TICKS_MUESTREO - 1);
    localparam logic [BIT_COUNTER-1:0] LAST_BIT = BIT_COUNTER'(MAXTAM - 1);

    // One-hot state encoding
    localparam logic [4:0] S_IDLE  = 5'b00001;
    localparam logic [4:0] S_START = 5'b00010;
    localparam logic [4:0] S_DATA  = 5'b00100;
    localparam logic [4:0] S_STOP  = 5'b01000;
    localparam logic [4:0] S_BREAK = 5'b10000;

    logic [4:0]             r_state;
    logic [3:0]             r_ticks;
    logic [BIT_COUNTER-1:0] r_idx;
    logic [MAXTAM-1:0]      r_shreg;
    logic [MAXTAM-1:0]      r_byte;
    logic                   r_done;
    logic                   r_err;
    logic                   r_rx_meta;
    logic                   r_rx_s;

    // Two-flop synchronizer. It resets to the idle line level so that
    // leaving reset does not look like a start bit.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= i_Rx_Serial;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_ticks <= '0;
            r_idx   <= '0;
            r_shreg <= '0;
            r_byte  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // Both status outputs are single-cycle pulses.
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_ticks <= '0;
                    end
                end
                S_START: begin
                    if (i_bd) begin
                        if (r_ticks == MID_START) begin
                            r_ticks <= '0;
                            if (!r_rx_s) begin
                                r_state <= S_DATA;
                                r_idx   <= '0;
                            end else begin
                                // The line went high again before the middle of
                                // the start bit, so treat it as a glitch.
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_ticks <= r_ticks + 4'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (i_bd) begin
                        if (r_ticks == LAST_TICK) begin
                            r_ticks <= '0;
                            // The LSB arrives first. Each new bit enters at
                            // the top and moves down as later bits arrive.
                            r_shreg <= {r_rx_s, r_shreg[MAXTAM-1:1]};
                            if (r_idx == LAST_BIT) begin
                                r_state <= S_STOP;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end else begin
                            r_ticks <= r_ticks + 4'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (i_bd) begin
                        if (r_ticks == LAST_TICK) begin
                            r_ticks <= '0;
                            // Return to idle at the middle of the stop bit.
                            // This catches a start bit that follows with no
                            // idle time between frames.
                            if (r_rx_s) begin
                                r_byte  <= r_shreg;
                                r_done  <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_err   <= 1'b1;
                                r_state <= S_BREAK;
                            end
                        end else begin
                            r_ticks <= r_ticks + 4'd1;
                        end
                    end
                end
                S_BREAK: begin
                    // A line held low after a bad stop bit must not be read
                    // as a stream of new start bits.
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_ticks <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ticks <= '0;
                end
            endcase
        end
    end

    assign o_Rx_Byte = r_byte;
    assign o_Rx_Done = r_done;
    assign o_Rx_Err  = r_err;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
//   Drives serial frames built from bytes, at a selectable baud-tick rate.
//   Every frame pushes its expected outcome (good byte or framing error) onto
//   a queue. A monitor pops one entry for each Done/Err pulse and compares.
//   The monitor also checks that o_Rx_Byte never changes without Done.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       bd      = 1'b0;
    logic       rx      = 1'b1;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic       rx_err;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    logic [7:0] model_last = 8'h00;
    logic [7:0] prev_byte  = 8'h00;
    int   bd_div = 1;
    int   bd_cnt = 0;

    uart_rx #(.MAXTAM(8), .BIT_COUNTER(3)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_bd        (bd),
        .i_Rx_Serial (rx),
        .o_Rx_Byte   (rx_byte),
        .o_Rx_Done   (rx_done),
        .o_Rx_Err    (rx_err)
    );

    always #5 clk = ~clk;

    // Baud tick: one pulse every bd_div clocks, changed away from the active edge.
    always @(negedge clk) begin
        if (bd_cnt >= bd_div - 1) begin
            bd_cnt = 0;
            bd     = 1'b1;
        end else begin
            bd_cnt = bd_cnt + 1;
            bd     = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            model_last = 8'h00;
            prev_byte  = 8'h00;
        end else begin
            if (rx_done && rx_err) check("done_err_exclusive", 32'd1, 32'd0);
            if (rx_done || rx_err) begin
                if (q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, rx_done, rx_err}, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind_err", {31'd0, rx_err}, {31'd0, e.is_err});
                    if (!e.is_err) begin
                        check("rx_byte", {24'd0, rx_byte}, {24'd0, e.data});
                        model_last = e.data;
                    end else begin
                        check("byte_held_on_err", {24'd0, rx_byte}, {24'd0, model_last});
                    end
                end
            end else begin
                check("byte_stable", {24'd0, rx_byte}, {24'd0, prev_byte});
            end
            prev_byte = rx_byte;
        end
    end

    // Wait for one baud tick consumed by the DUT, then step off the edge.
    task automatic tick();
        do @(posedge clk); while (bd !== 1'b1);
        #1;
    endtask

    task automatic hold(input logic lvl, input int n);
        rx = lvl;
        repeat (n) tick();
    endtask

    // Transmitter model: start bit, 8 data bits LSB first, stop bit; 16 ticks each.
    task automatic send(input logic [7:0] d, input logic stop);
        exp_t e;
        e.is_err = !stop;
        e.data   = d;
        q.push_back(e);
        hold(1'b0, 16);
        for (int i = 0; i < 8; i++) hold(d[i], 16);
        hold(stop, 16);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d81;
        int         n;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_byte", {24'd0, rx_byte}, 32'd0);
        check("reset_done", {31'd0, rx_done}, 32'd0);
        check("reset_err",  {31'd0, rx_err},  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        hold(1'b1, 20);

        // T1: basic frame
        send(8'hA5, 1'b1);
        hold(1'b1, 20);

        // T2: short glitch is rejected, then a normal frame
        hold(1'b0, 4);
        hold(1'b1, 30);
        send(8'h3C, 1'b1);
        hold(1'b1, 10);

        // T3: bad stop bit, line held low, then recovery
        send(8'hFF, 1'b0);
        hold(1'b0, 40);
        hold(1'b1, 10);
        send(8'h5A, 1'b1);
        hold(1'b1, 10);

        // T4: back-to-back frames with no idle time
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        hold(1'b1, 10);

        // T5: reset in the middle of data bit 4 of 0x81
        d81 = 8'h81;
        hold(1'b0, 16);
        for (int i = 0; i < 4; i++) hold(d81[i], 16);
        hold(d81[4], 8);
        @(posedge clk); #2;
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        check("midframe_reset_byte", {24'd0, rx_byte}, 32'd0);
        check("midframe_reset_done", {31'd0, rx_done}, 32'd0);
        check("midframe_reset_err",  {31'd0, rx_err},  32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        hold(1'b1, 20);
        send(8'h7E, 1'b1);
        hold(1'b1, 10);

        // T6: transmitter-style stream with a shared tick every 4 clocks
        bd_div = 4;
        hold(1'b1, 4);
        send(8'h01, 1'b1);
        send(8'h80, 1'b1);
        send(8'h55, 1'b1);
        hold(1'b1, 10);

        // Random frames: random rate, gaps and occasional framing errors
        for (int k = 0; k < 20; k++) begin
            logic [7:0] d;
            int sel;
            sel = $urandom_range(0, 2);
            bd_div = (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
            d = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                send(d, 1'b0);
                hold(1'b0, $urandom_range(0, 30));
                hold(1'b1, 4 + $urandom_range(0, 8));
            end else begin
                send(d, 1'b1);
                hold(1'b1, $urandom_range(0, 12));
            end
        end
        hold(1'b1, 40);

        // Drain the scoreboard within a bounded time.
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
